tdd_frame_sched: RTL and testbench

TDD_FRAME_SCHED -- requirements
Module: tdd_frame_sched

---
 rtl/tdd_frame_sched.sv | 133 +++++++++++++
 tb/tb_tdd_frame_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdd_frame_sched.sv
// TDD frame scheduler: sample-position counter with one-shot length adjustment and TX/RX windows.
// Optional build macro TDD_FRAME_NUM_EN adds the 32-bit completed-frame counter on frame_num.
module tdd_frame_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        tddmode,
   input  logic        sample_tick,
   input  logic [23:0] frame_len,
   input  logic [23:0] frame_adj,
   input  logic        adj_wr,
   input  logic [23:0] tstart,
   input  logic [23:0] tend,
   input  logic [23:0] rstart,
   input  logic [23:0] rend,
   output logic [23:0] pos,
   output logic        frame_start,
   output logic        tx_win,
   output logic        rx_win,
   output logic        adj_pending,
   output logic [31:0] frame_num,
   output logic        o_dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [23:0] r_pos;
   logic        r_frame_start;
   logic        r_adj_pending;
   logic [23:0] r_adj;
   logic [23:0] r_cur_len;

   logic        w_wrap;
   logic        w_start;
   logic [25:0] w_sum;
   logic        w_adj_ok;
   logic [23:0] w_raw_len;
   logic [23:0] w_new_len;
   logic        w_tx_in;
   logic        w_rx_in;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Valid/ready-free control: en gates the FSM, sample_tick advances pos only in RUN.
   always_comb begin
      w_next_state = r_state;
      w_wrap       = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_next_state = S_RUN;
               w_start      = 1'b1;
            end
         end
         S_RUN: begin
            if (!en) begin
               w_next_state = S_IDLE;
            end else if (sample_tick && (r_pos >= r_cur_len - 24'd1)) begin
               w_wrap  = 1'b1;
               w_start = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Extra headroom bit so both negative and >2^24-1 results are detectable.
   always_comb begin
      w_sum     = {2'b00, frame_len} + {{2{r_adj[23]}}, r_adj};
      w_adj_ok  = r_adj_pending && (w_sum[25:24] == 2'b00) && (w_sum[23:0] != 24'd0);
      w_raw_len = (w_wrap && w_adj_ok) ? w_sum[23:0] : frame_len;
      w_new_len = (w_raw_len == 24'd0) ? 24'd1 : w_raw_len;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos         <= 24'd0;
         r_frame_start <= 1'b0;
         r_adj_pending <= 1'b0;
         r_adj         <= 24'd0;
         r_cur_len     <= 24'd1;
      end else begin
         r_frame_start <= w_start;
         if (w_start) begin
            r_pos     <= 24'd0;
            r_cur_len <= w_new_len;
         end else if (w_next_state == S_IDLE) begin
            r_pos <= 24'd0;
         end else if (sample_tick) begin
            r_pos <= r_pos + 24'd1;
         end
         // A write landing on the wrap cycle stays pending for the following wrap.
         if (adj_wr) begin
            r_adj_pending <= 1'b1;
            r_adj         <= frame_adj;
         end else if (w_wrap) begin
            r_adj_pending <= 1'b0;
         end
      end
   end

`ifdef TDD_FRAME_NUM_EN
   logic [31:0] r_frame_num;
   always_ff @(posedge clk) begin
      if (rst)         r_frame_num <= 32'd0;
      else if (w_wrap) r_frame_num <= r_frame_num + 32'd1;
   end
   assign frame_num = r_frame_num;
`else
   assign frame_num = 32'd0;
`endif

   always_comb begin
      if (tstart <= tend) w_tx_in = (r_pos >= tstart) && (r_pos <= tend);
      else                w_tx_in = (r_pos >= tstart) || (r_pos <= tend);
      if (rstart <= rend) w_rx_in = (r_pos >= rstart) && (r_pos <= rend);
      else                w_rx_in = (r_pos >= rstart) || (r_pos <= rend);
   end

   assign tx_win      = (r_state == S_RUN) && (!tddmode || w_tx_in);
   assign rx_win      = (r_state == S_RUN) && (!tddmode || w_rx_in);
   assign pos         = r_pos;
   assign frame_start = r_frame_start;
   assign adj_pending = r_adj_pending;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tdd_frame_sched.sv
// Directed testbench for tdd_frame_sched; expected values are hand-derived per scenario.
// frame_num expectations follow TDD_FRAME_NUM_EN (counter when defined, constant 0 otherwise).
module tb_tdd_frame_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        tddmode = 1'b1;
   logic        sample_tick = 1'b0;
   logic [23:0] frame_len = 24'd8;
   logic [23:0] frame_adj = 24'd0;
   logic        adj_wr = 1'b0;
   logic [23:0] tstart = 24'd0;
   logic [23:0] tend = 24'd3;
   logic [23:0] rstart = 24'd4;
   logic [23:0] rend = 24'd7;
   logic [23:0] pos;
   logic        frame_start;
   logic        tx_win;
   logic        rx_win;
   logic        adj_pending;
   logic [31:0] frame_num;
   logic        o_dbg_state;

   int checks = 0;
   int errors = 0;

   tdd_frame_sched dut (
      .clk(clk), .rst(rst), .en(en), .tddmode(tddmode), .sample_tick(sample_tick),
      .frame_len(frame_len), .frame_adj(frame_adj), .adj_wr(adj_wr),
      .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
      .pos(pos), .frame_start(frame_start), .tx_win(tx_win), .rx_win(rx_win),
      .adj_pending(adj_pending), .frame_num(frame_num), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_fn(input int n);
`ifdef TDD_FRAME_NUM_EN
      return n;
`else
      return 32'd0 + (n & 0);
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; adj_wr = 1'b0; sample_tick = 1'b0; tddmode = 1'b1;
      wait_cycle();
      wait_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; sample_tick = 1'b1; adj_wr = 1'b1; frame_adj = 24'd5;
      tstart = 24'd0; tend = 24'd7; rstart = 24'd0; rend = 24'd7;
      wait_cycle();
      wait_cycle();
      checks++; if (pos !== 24'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
      checks++; if (tx_win !== 1'b0 || rx_win !== 1'b0) begin errors++; $display("FAIL reset_win got %b%b exp 00", tx_win, rx_win); end
      checks++; if (adj_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", adj_pending); end
      checks++; if (frame_num !== 32'd0) begin errors++; $display("FAIL reset_fnum got %0d exp 0", frame_num); end
      checks++; if (o_dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", o_dbg_state); end
      rst = 1'b0; en = 1'b0; adj_wr = 1'b0; sample_tick = 1'b0;
   endtask

   task automatic test_basic();
      int p;
      do_reset();
      frame_len = 24'd8; tstart = 24'd0; tend = 24'd3; rstart = 24'd4; rend = 24'd7;
      en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         wait_cycle();
         p = (c - 1) % 8;
         checks++; if (pos !== p[23:0]) begin errors++; $display("FAIL basic_pos c=%0d got %0d exp %0d", c, pos, p); end
         checks++; if (frame_start !== (p == 0)) begin errors++; $display("FAIL basic_fs c=%0d got %b exp %b", c, frame_start, p == 0); end
         checks++; if (tx_win !== (p <= 3) || rx_win !== (p >= 4)) begin errors++; $display("FAIL basic_win c=%0d got %b%b", c, tx_win, rx_win); end
         checks++; if (frame_num !== exp_fn((c - 1) / 8)) begin errors++; $display("FAIL basic_fnum c=%0d got %0d exp %0d", c, frame_num, exp_fn((c - 1) / 8)); end
      end
      checks++; if (o_dbg_state !== 1'b1) begin errors++; $display("FAIL basic_state got %b exp 1", o_dbg_state); end
   endtask

   task automatic test_tick_hold();
      logic [20:0] pat;
      logic        prev;
      int          ep;
      pat = 21'b1_1101_1111_0110_0110_1000;
      do_reset();
      frame_len = 24'd8; en = 1'b1; sample_tick = 1'b0; prev = 1'b0; ep = 0;
      for (int c = 1; c <= 20; c++) begin
         wait_cycle();
         if (c >= 2 && prev) ep = (ep == 7) ? 0 : ep + 1;
         checks++; if (pos !== ep[23:0]) begin errors++; $display("FAIL hold_pos c=%0d got %0d exp %0d", c, pos, ep); end
         sample_tick = pat[c];
         prev = pat[c];
      end
   endtask

   task automatic test_adj_neg();
      int ep;
      do_reset();
      frame_len = 24'd10; en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         wait_cycle();
         ep = (c < 11) ? c - 1 : (c < 18) ? c - 11 : (c < 28) ? c - 18 : c - 28;
         checks++; if (pos !== ep[23:0]) begin errors++; $display("FAIL adjneg_pos c=%0d got %0d exp %0d", c, pos, ep); end
         checks++; if (frame_start !== (ep == 0)) begin errors++; $display("FAIL adjneg_fs c=%0d got %b", c, frame_start); end
         checks++; if (adj_pending !== (c >= 5 && c < 11)) begin errors++; $display("FAIL adjneg_pend c=%0d got %b", c, adj_pending); end
         adj_wr = (c == 4); frame_adj = 24'hFFFFFD;
      end
   endtask

   task automatic test_adj_on_wrap();
      int ep;
      do_reset();
      frame_len = 24'd4; en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         wait_cycle();
         ep = (c < 5) ? c - 1 : (c < 9) ? c - 5 : (c < 15) ? c - 9 : (c < 19) ? c - 15 : c - 19;
         checks++; if (pos !== ep[23:0]) begin errors++; $display("FAIL adjwrap_pos c=%0d got %0d exp %0d", c, pos, ep); end
         checks++; if (adj_pending !== (c >= 5 && c < 9)) begin errors++; $display("FAIL adjwrap_pend c=%0d got %b", c, adj_pending); end
         adj_wr = (c == 4); frame_adj = 24'd2;
      end
   endtask

   task automatic test_adj_discard();
      int ep;
      do_reset();
      frame_len = 24'd5; en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         wait_cycle();
         ep = (c < 6) ? c - 1 : (c < 11) ? c - 6 : c - 11;
         checks++; if (pos !== ep[23:0]) begin errors++; $display("FAIL discard_pos c=%0d got %0d exp %0d", c, pos, ep); end
         checks++; if (adj_pending !== (c >= 3 && c < 6)) begin errors++; $display("FAIL discard_pend c=%0d got %b", c, adj_pending); end
         adj_wr = (c == 2); frame_adj = 24'hFFFFFB;
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      frame_len = 24'd0; en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         wait_cycle();
         checks++; if (pos !== 24'd0) begin errors++; $display("FAIL zero_pos c=%0d got %0d exp 0", c, pos); end
         checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL zero_fs c=%0d got %b exp 1", c, frame_start); end
         checks++; if (frame_num !== exp_fn(c - 1)) begin errors++; $display("FAIL zero_fnum c=%0d got %0d exp %0d", c, frame_num, exp_fn(c - 1)); end
      end
   endtask

   task automatic test_windows();
      int p;
      do_reset();
      frame_len = 24'd8; tstart = 24'd6; tend = 24'd1; rstart = 24'd2; rend = 24'd5;
      en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         wait_cycle();
         p = (c - 1) % 8;
         checks++; if (tx_win !== (p >= 6 || p <= 1)) begin errors++; $display("FAIL wrapwin_tx c=%0d pos=%0d got %b", c, p, tx_win); end
         checks++; if (rx_win !== (p >= 2 && p <= 5)) begin errors++; $display("FAIL wrapwin_rx c=%0d pos=%0d got %b", c, p, rx_win); end
      end
      tddmode = 1'b0;
      for (int c = 17; c <= 24; c++) begin
         wait_cycle();
         checks++; if (tx_win !== 1'b1 || rx_win !== 1'b1) begin errors++; $display("FAIL fdd_win c=%0d got %b%b exp 11", c, tx_win, rx_win); end
      end
      tddmode = 1'b1;
   endtask

   task automatic test_en_drop();
      do_reset();
      frame_len = 24'd4; tstart = 24'd0; tend = 24'd3; rstart = 24'd0; rend = 24'd3;
      en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         wait_cycle();
         if (c >= 8 && c <= 10) begin
            checks++; if (pos !== 24'd0 || o_dbg_state !== 1'b0) begin errors++; $display("FAIL endrop_idle c=%0d pos %0d state %b", c, pos, o_dbg_state); end
            checks++; if (tx_win !== 1'b0 || rx_win !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL endrop_out c=%0d got %b%b%b", c, tx_win, rx_win, frame_start); end
            checks++; if (adj_pending !== 1'b1) begin errors++; $display("FAIL endrop_pend c=%0d got %b exp 1", c, adj_pending); end
            checks++; if (frame_num !== exp_fn(1)) begin errors++; $display("FAIL endrop_fnum c=%0d got %0d exp %0d", c, frame_num, exp_fn(1)); end
         end
         if (c == 11) begin
            checks++; if (pos !== 24'd0 || frame_start !== 1'b1 || o_dbg_state !== 1'b1) begin errors++; $display("FAIL reenable c=%0d pos %0d fs %b", c, pos, frame_start); end
            checks++; if (adj_pending !== 1'b1) begin errors++; $display("FAIL reenable_pend got %b exp 1", adj_pending); end
         end
         adj_wr = (c == 6); frame_adj = 24'd1;
         en = !(c >= 7 && c <= 9);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      frame_len = 24'd8; tstart = 24'd0; tend = 24'd7; rstart = 24'd0; rend = 24'd7;
      en = 1'b1; sample_tick = 1'b1;
      for (int c = 1; c <= 6; c++) wait_cycle();
      checks++; if (pos !== 24'd5) begin errors++; $display("FAIL rstmid_pre got %0d exp 5", pos); end
      rst = 1'b1; adj_wr = 1'b1; frame_adj = 24'd3;
      wait_cycle();
      rst = 1'b0; adj_wr = 1'b0;
      checks++; if (pos !== 24'd0 || o_dbg_state !== 1'b0) begin errors++; $display("FAIL rstmid_idle pos %0d state %b", pos, o_dbg_state); end
      checks++; if (adj_pending !== 1'b0 || frame_num !== 32'd0) begin errors++; $display("FAIL rstmid_clr pend %b fnum %0d", adj_pending, frame_num); end
      checks++; if (tx_win !== 1'b0 || rx_win !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL rstmid_out got %b%b%b exp 000", tx_win, rx_win, frame_start); end
      wait_cycle();
      checks++; if (frame_start !== 1'b1 || pos !== 24'd0 || o_dbg_state !== 1'b1) begin errors++; $display("FAIL rstmid_reen fs %b pos %0d", frame_start, pos); end
      wait_cycle();
      checks++; if (pos !== 24'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL rstmid_run pos %0d exp 1 fs %b", pos, frame_start); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tick_hold();
      test_adj_neg();
      test_adj_on_wrap();
      test_adj_discard();
      test_zero_len();
      test_windows();
      test_en_drop();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
